fifo_rptr_handler: RTL and testbench

Read-side control stage of the parameterized async FIFO. It sits between the read port of fifo_memory and the read-domain consumer. It owns the binary and gray read pointers, synchronizes the gray write pointer into the read domain, and generates empty and fill-level status. It presents memory data through a first-word-fall-through (FWFT) output register with a valid/ready handshake.

---
 rtl/fifo_rptr_handler.sv | 115 +++++++++++
 tb/tb_fifo_rptr_handler.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rptr_handler.sv
// Read-side control of the async FIFO: read pointers, write-pointer synchronizer,
// empty/fill status and a first-word-fall-through output register.
module fifo_rptr_handler #(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int PTR_WIDTH  = 4
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic [PTR_WIDTH:0]    g_wptr_async,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic [PTR_WIDTH:0]    b_rptr,
  output logic [PTR_WIDTH:0]    g_rptr,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    rd_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready
);

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
    $error("fifo_rptr_handler: DEPTH must equal 2**PTR_WIDTH");
  end

  function automatic logic [PTR_WIDTH:0] gray2bin(input logic [PTR_WIDTH:0] g);
    logic [PTR_WIDTH:0] b;
    b[PTR_WIDTH] = g[PTR_WIDTH];
    for (int i = PTR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PTR_WIDTH:0]    wq1_r;
  logic [PTR_WIDTH:0]    wq2_r;
  logic [PTR_WIDTH:0]    b_rptr_r;
  logic [PTR_WIDTH:0]    g_rptr_r;
  logic [DATA_WIDTH-1:0] dout_r;
  out_state_t            state_r;
  out_state_t            state_s;
  logic                  empty_s;
  logic                  pop_s;
  logic [PTR_WIDTH:0]    b_rptr_inc_s;

  assign empty_s      = (g_rptr_r == wq2_r);
  assign pop_s        = !empty_s && ((state_r == OUT_EMPTY) || dout_ready);
  assign b_rptr_inc_s = b_rptr_r + (PTR_WIDTH+1)'(1);

  // Two-flop synchronizer for the gray write pointer; no logic between stages.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      wq1_r <= '0;
      wq2_r <= '0;
    end else begin
      wq1_r <= g_wptr_async;
      wq2_r <= wq1_r;
    end
  end

  // Read pointers and output word advance together on a pop.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr_r <= '0;
      g_rptr_r <= '0;
      dout_r   <= '0;
    end else if (pop_s) begin
      b_rptr_r <= b_rptr_inc_s;
      g_rptr_r <= b_rptr_inc_s ^ (b_rptr_inc_s >> 1);
      dout_r   <= mem_data;
    end else begin
      b_rptr_r <= b_rptr_r;
      g_rptr_r <= g_rptr_r;
      dout_r   <= dout_r;
    end
  end

  // Output register occupancy state.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_r <= OUT_EMPTY;
    end else begin
      state_r <= state_s;
    end
  end

  // A pop always refills the output register; an accept without a pop drains it.
  always_comb begin
    state_s = state_r;
    case (state_r)
      OUT_EMPTY: begin
        if (pop_s) state_s = OUT_FULL;
        else       state_s = OUT_EMPTY;
      end
      OUT_FULL: begin
        if (pop_s)           state_s = OUT_FULL;
        else if (dout_ready) state_s = OUT_EMPTY;
        else                 state_s = OUT_FULL;
      end
      default: state_s = OUT_EMPTY;
    endcase
  end

  assign b_rptr     = b_rptr_r;
  assign g_rptr     = g_rptr_r;
  assign empty      = empty_s;
  assign rd_count   = gray2bin(wq2_r) - b_rptr_r;
  assign dout       = dout_r;
  assign dout_valid = (state_r == OUT_FULL);

endmodule

// File: tb/tb_fifo_rptr_handler.sv
// Directed bench for fifo_rptr_handler with a behavioural read-port memory.
module tb_fifo_rptr_handler;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic [4:0] g_wptr_async;
  logic [7:0] mem_data;
  logic [4:0] b_rptr;
  logic [4:0] g_rptr;
  logic       empty;
  logic [4:0] rd_count;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;

  logic [7:0] mem [16];
  int total = 0;
  int bad   = 0;

  always #5 rclk = ~rclk;

  assign mem_data = mem[b_rptr[3:0]];

  fifo_rptr_handler #(.DEPTH(16), .DATA_WIDTH(8), .PTR_WIDTH(4)) dut (
    .rclk         (rclk),
    .rrst_n       (rrst_n),
    .g_wptr_async (g_wptr_async),
    .mem_data     (mem_data),
    .b_rptr       (b_rptr),
    .g_rptr       (g_rptr),
    .empty        (empty),
    .rd_count     (rd_count),
    .dout         (dout),
    .dout_valid   (dout_valid),
    .dout_ready   (dout_ready)
  );

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_b_rptr"}, 32'(b_rptr), 32'h0);
    chk({tag, "_g_rptr"}, 32'(g_rptr), 32'h0);
    chk({tag, "_dout"}, 32'(dout), 32'h0);
    chk({tag, "_dout_valid"}, 32'(dout_valid), 32'h0);
    chk({tag, "_empty"}, 32'(empty), 32'h1);
    chk({tag, "_rd_count"}, 32'(rd_count), 32'h0);
  endtask

  task automatic do_reset();
    rrst_n       = 1'b0;
    g_wptr_async = 5'b00000;
    dout_ready   = 1'b0;
    tick();
    rrst_n = 1'b1;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    rrst_n       = 1'b0;
    dout_ready   = 1'b0;
    g_wptr_async = 5'(($urandom_range(1, 31)));

    // 1: reset with random write pointer, then release with pointer at 0
    tick();
    g_wptr_async = 5'(($urandom_range(1, 31)));
    tick();
    check_reset_vals("rst");
    g_wptr_async = 5'b00000;
    rrst_n = 1'b1;
    tick();
    tick();
    tick();
    check_reset_vals("rst_rel");

    // 2: single word, three-edge latency
    mem[0] = 8'hA5;
    g_wptr_async = 5'b00001;
    tick();
    chk("t2_e1_valid", 32'(dout_valid), 32'h0);
    chk("t2_e1_empty", 32'(empty), 32'h1);
    tick();
    chk("t2_e2_valid", 32'(dout_valid), 32'h0);
    chk("t2_e2_count", 32'(rd_count), 32'h1);
    tick();
    chk("t2_e3_valid", 32'(dout_valid), 32'h1);
    chk("t2_e3_dout", 32'(dout), 32'hA5);
    chk("t2_e3_b_rptr", 32'(b_rptr), 32'h1);
    chk("t2_e3_g_rptr", 32'(g_rptr), 32'h01);
    chk("t2_e3_empty", 32'(empty), 32'h1);
    dout_ready = 1'b1;
    tick();
    chk("t2_drain_valid", 32'(dout_valid), 32'h0);
    chk("t2_drain_b_rptr", 32'(b_rptr), 32'h1);

    // 3: backpressure then drain
    do_reset();
    for (int i = 0; i < 4; i++) mem[i] = 8'h10 + 8'(i);
    g_wptr_async = 5'b00110;
    tick();
    tick();
    tick();
    chk("t3_pop1_dout", 32'(dout), 32'h10);
    chk("t3_pop1_count", 32'(rd_count), 32'h3);
    tick();
    tick();
    chk("t3_hold_dout", 32'(dout), 32'h10);
    chk("t3_hold_valid", 32'(dout_valid), 32'h1);
    chk("t3_hold_b_rptr", 32'(b_rptr), 32'h1);
    dout_ready = 1'b1;
    tick();
    chk("t3_d11", 32'(dout), 32'h11);
    tick();
    chk("t3_d12", 32'(dout), 32'h12);
    tick();
    chk("t3_d13", 32'(dout), 32'h13);
    chk("t3_d13_valid", 32'(dout_valid), 32'h1);
    chk("t3_b_rptr", 32'(b_rptr), 32'h4);
    chk("t3_empty", 32'(empty), 32'h1);
    tick();
    chk("t3_end_valid", 32'(dout_valid), 32'h0);

    // 4: wrap-around, advance to b_rptr=15 by traffic
    g_wptr_async = 5'b01000;
    for (int i = 0; i < 16; i++) tick();
    chk("t4_pre_b_rptr", 32'(b_rptr), 32'hF);
    chk("t4_pre_g_rptr", 32'(g_rptr), 32'h08);
    chk("t4_pre_valid", 32'(dout_valid), 32'h0);
    dout_ready = 1'b0;
    mem[15] = 8'hF5;
    mem[0]  = 8'hE0;
    g_wptr_async = 5'b11001;
    tick();
    tick();
    chk("t4_count", 32'(rd_count), 32'h2);
    chk("t4_empty0", 32'(empty), 32'h0);
    tick();
    chk("t4_pop15_dout", 32'(dout), 32'hF5);
    chk("t4_pop15_b_rptr", 32'(b_rptr), 32'h10);
    chk("t4_pop15_g_rptr", 32'(g_rptr), 32'h18);
    dout_ready = 1'b1;
    tick();
    chk("t4_pop0_dout", 32'(dout), 32'hE0);
    chk("t4_pop0_b_rptr", 32'(b_rptr), 32'h11);
    chk("t4_pop0_empty", 32'(empty), 32'h1);
    tick();
    chk("t4_end_valid", 32'(dout_valid), 32'h0);

    // 5: full storage, 16 back-to-back words
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h30 + 8'(i * 3);
    dout_ready   = 1'b1;
    g_wptr_async = 5'b11000;
    tick();
    tick();
    chk("t5_full_empty", 32'(empty), 32'h0);
    chk("t5_full_count", 32'(rd_count), 32'h10);
    for (int k = 0; k < 16; k++) begin
      tick();
      chk($sformatf("t5_word%0d", k), 32'(dout), 32'h30 + 32'(k * 3));
      chk($sformatf("t5_valid%0d", k), 32'(dout_valid), 32'h1);
    end
    chk("t5_end_empty", 32'(empty), 32'h1);
    chk("t5_end_b_rptr", 32'(b_rptr), 32'h10);
    tick();
    chk("t5_end_valid", 32'(dout_valid), 32'h0);

    // 6: asynchronous reset mid-stream
    do_reset();
    g_wptr_async = 5'b00101;
    tick();
    tick();
    tick();
    chk("t6_pre_valid", 32'(dout_valid), 32'h1);
    chk("t6_pre_count", 32'(rd_count), 32'h5);
    #2;
    rrst_n = 1'b0;
    g_wptr_async = 5'b00000;
    #1;
    check_reset_vals("t6_async");
    tick();
    rrst_n = 1'b1;
    tick();
    tick();
    tick();
    check_reset_vals("t6_rel");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
